// File: rtl/audio_sample_feeder.sv
// Sample memory -> prefetch FIFO -> one PCM sample per I2S frame (LRCLK fall).
// Define AUDIO_FEEDER_LOOP_EN to wrap at LAST_ADDR instead of stopping.
module audio_sample_feeder #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 20'h0FFFF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              PLAY,
  input  logic              LRCLK,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic [DATA_W-1:0] SAMPLE,
  output logic              SAMPLE_STB,
  output logic              DONE,
  output logic [7:0]        UNDERRUN
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_e;

  fetch_e r_state;
  logic r_mem_rd;
  logic [ADDR_W-1:0] r_addr;
  logic r_end;

  logic r_lr_s1;
  logic r_lr_s2;
  logic r_lr_prev;

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [DATA_W-1:0] r_sample;
  logic r_stb;
  logic r_done;
  logic [7:0] r_underrun;

  logic w_lr_fall;
  logic w_frame;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_lr_fall = r_lr_prev & ~r_lr_s2;
  assign w_frame = w_lr_fall & PLAY;
  assign w_empty = (r_count == '0);
  assign w_full = (r_count == DEPTH_C);
  // An ACK that lands after PLAY drops is absorbed but never stored.
  assign w_push = (r_state == S_WAIT) & MEM_ACK & PLAY;
  assign w_pop = w_frame & ~w_empty;

  assign MEM_ADDR = r_addr;
  assign MEM_RD = r_mem_rd;
  assign SAMPLE = r_sample;
  assign SAMPLE_STB = r_stb;
  assign DONE = r_done;
  assign UNDERRUN = r_underrun;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lr_s1 <= 1'b1;
      r_lr_s2 <= 1'b1;
      r_lr_prev <= 1'b1;
    end else begin
      r_lr_s1 <= LRCLK;
      r_lr_s2 <= r_lr_s1;
      r_lr_prev <= r_lr_s2;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_mem_rd <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (PLAY && !w_full && !r_end) begin
            r_state <= S_REQ;
            r_mem_rd <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
          r_mem_rd <= 1'b0;
        end
        S_WAIT: begin
          if (MEM_ACK) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mem_rd <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_addr <= START_ADDR;
      r_end <= 1'b0;
    end else if (!PLAY) begin
      r_addr <= START_ADDR;
      r_end <= 1'b0;
    end else if (w_push) begin
      if (r_addr == LAST_ADDR) begin
`ifdef AUDIO_FEEDER_LOOP_EN
        r_addr <= START_ADDR;
`else
        r_end <= 1'b1;
`endif
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= MEM_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else if (!PLAY) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10: r_count <= r_count + CNT_W'(1);
        2'b01: r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pop decision uses the pre-push count, so an empty frame never sees
  // data arriving in the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sample <= '0;
      r_stb <= 1'b0;
      r_done <= 1'b0;
      r_underrun <= '0;
    end else begin
      r_stb <= 1'b0;
      if (!PLAY) begin
        r_sample <= '0;
        r_done <= 1'b0;
      end else begin
        if (w_frame) begin
          r_stb <= 1'b1;
          r_sample <= w_empty ? '0 : r_fifo[r_rd_ptr];
          if (w_empty && !r_end && (r_underrun != 8'hFF)) begin
            r_underrun <= r_underrun + 8'd1;
          end
        end
        if (r_end && w_empty) begin
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Scoreboard bench: two feeders (full range and LAST_ADDR=3) with memory models.
// Stimulus queues expected samples; a negedge monitor checks value and latency.
module tb_audio_sample_feeder;

  typedef struct {
    logic [15:0] v;
    int due;
  } exp_t;

  localparam int BIG = 32'h7fff_ffff;

  logic clk;
  logic rst_n [2];
  logic play [2];
  logic lrclk [2];
  logic [19:0] mem_addr [2];
  logic mem_rd [2];
  logic mem_ack [2];
  logic [15:0] mem_data [2];
  logic [15:0] sample [2];
  logic stb [2];
  logic done [2];
  logic [7:0] under [2];

  int lat [2];
  int wc [2];
  bit pend [2];
  logic [19:0] req_addr [2];
  int rd_cnt [2];

  int cyc;
  int n_tests;
  int n_fail;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m_e;
  bit m_got;

  audio_sample_feeder u_a (
    .CLK(clk), .RESET_N(rst_n[0]), .PLAY(play[0]), .LRCLK(lrclk[0]),
    .MEM_ADDR(mem_addr[0]), .MEM_RD(mem_rd[0]), .MEM_ACK(mem_ack[0]),
    .MEM_DATA(mem_data[0]), .SAMPLE(sample[0]), .SAMPLE_STB(stb[0]),
    .DONE(done[0]), .UNDERRUN(under[0])
  );

  audio_sample_feeder #(.LAST_ADDR(20'd3)) u_b (
    .CLK(clk), .RESET_N(rst_n[1]), .PLAY(play[1]), .LRCLK(lrclk[1]),
    .MEM_ADDR(mem_addr[1]), .MEM_RD(mem_rd[1]), .MEM_ACK(mem_ack[1]),
    .MEM_DATA(mem_data[1]), .SAMPLE(sample[1]), .SAMPLE_STB(stb[1]),
    .DONE(done[1]), .UNDERRUN(under[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory returns data = address, lat cycles after the request cycle
  for (genvar g = 0; g < 2; g++) begin : g_mem
    initial begin
      forever begin
        @(negedge clk);
        mem_ack[g] = 1'b0;
        if (pend[g]) begin
          wc[g]++;
          if (wc[g] >= lat[g]) begin
            mem_ack[g] = 1'b1;
            mem_data[g] = req_addr[g][15:0];
            pend[g] = 1'b0;
          end
        end
        if (mem_rd[g] === 1'b1) begin
          pend[g] = 1'b1;
          wc[g] = 0;
          req_addr[g] = mem_addr[g];
          rd_cnt[g]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (stb[k] === 1'b1) begin
        m_got = 1'b0;
        if (k == 0 && q0.size() > 0) begin
          m_e = q0.pop_front();
          m_got = 1'b1;
        end else if (k == 1 && q1.size() > 0) begin
          m_e = q1.pop_front();
          m_got = 1'b1;
        end
        n_tests++;
        if (!m_got) begin
          n_fail++;
          $display("FAIL stb_unexpected[%0d]: got sample %h, required no strobe",
                   k, sample[k]);
        end else if (sample[k] !== m_e.v || cyc != m_e.due) begin
          n_fail++;
          $display("FAIL sample[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                   k, sample[k], cyc, m_e.v, m_e.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  function automatic void push_exp(input int k, input logic [15:0] v);
    exp_t e;
    e.v = v;
    e.due = cyc + 3;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // call at a negedge; leaves LRCLK high, returns at a negedge
  task automatic frame(input int k, input logic [15:0] v, input int half);
    lrclk[k] = 1'b0;
    push_exp(k, v);
    repeat (half) @(negedge clk);
    lrclk[k] = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic wait_rd(input int k, output logic [19:0] a);
    bit ok;
    ok = 1'b0;
    a = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_rd[k] === 1'b1) begin
        a = mem_addr[k];
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_rd[%0d]: got no MEM_RD in 300 cycles, required one", k);
    end
  endtask

  task automatic chk_reset(input int k);
    chk("rst_sample", sample[k], 0);
    chk("rst_stb", stb[k], 0);
    chk("rst_mem_rd", mem_rd[k], 0);
    chk("rst_mem_addr", mem_addr[k], 0);
    chk("rst_done", done[k], 0);
    chk("rst_underrun", under[k], 0);
  endtask

  logic [19:0] a;
  logic [15:0] exp_b [6];
  bit loop_en;

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      play[k] = 1'b0;
      lrclk[k] = 1'b1;
      mem_ack[k] = 1'b0;
      mem_data[k] = '0;
      lat[k] = 2;
      wc[k] = 0;
      pend[k] = 1'b0;
      req_addr[k] = '0;
      rd_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    // prefetch fills exactly 8, then samples stream 0,1,2,...
    play[0] = 1'b1;
    repeat (60) @(negedge clk);
    chk("prefetch_reqs", rd_cnt[0], 8);
    for (int i = 0; i < 10; i++) frame(0, 16'(i), 32);
    chk("steady_underrun", under[0], 0);

    // stop while a request is pending, then restart from the top
    lat[0] = 20;
    lrclk[0] = 1'b0;
    push_exp(0, 16'd10);
    wait_rd(0, a);
    chk("refill_addr", a, 18);
    repeat (2) @(negedge clk);
    play[0] = 1'b0;
    repeat (12) @(negedge clk);
    lrclk[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("stop_sample", sample[0], 0);
    chk("stop_addr", mem_addr[0], 0);
    chk("stop_mem_rd", mem_rd[0], 0);
    lat[0] = 2;
    play[0] = 1'b1;
    wait_rd(0, a);
    chk("rewind_addr", a, 0);
    repeat (40) @(negedge clk);
    frame(0, 16'd0, 32);
    frame(0, 16'd1, 32);

    // memory never answers: every frame is empty, count saturates
    play[0] = 1'b0;
    repeat (4) @(negedge clk);
    lat[0] = BIG;
    play[0] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      frame(0, 16'd0, 8);
      chk("underrun_cnt", under[0], (i < 255) ? i + 1 : 255);
    end

    // ACK coincides with a pop at count=1
    play[0] = 1'b0;
    lat[0] = 2;
    repeat (6) @(negedge clk);
    play[0] = 1'b1;
    wait_rd(0, a);
    chk("sim_addr0", a, 0);
    wait_rd(0, a);
    chk("sim_addr1", a, 1);
    lrclk[0] = 1'b0;
    push_exp(0, 16'd0);
    repeat (3) @(negedge clk);
    #1 lat[0] = BIG;
    repeat (5) @(negedge clk);
    lrclk[0] = 1'b1;
    repeat (8) @(negedge clk);
    frame(0, 16'd1, 8);
    frame(0, 16'd0, 8);
    chk("sim_underrun", under[0], 255);

    // asynchronous reset with a request outstanding
    rst_n[0] = 1'b0;
    #1;
    chk_reset(0);
    play[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    lat[0] = 2;
    repeat (6) @(negedge clk);
    play[0] = 1'b1;
    wait_rd(0, a);
    chk("post_rst_addr", a, 0);
    repeat (30) @(negedge clk);
    frame(0, 16'd0, 16);
    frame(0, 16'd1, 16);
    chk("post_rst_underrun", under[0], 0);

    // end of stream with LAST_ADDR=3
`ifdef AUDIO_FEEDER_LOOP_EN
    loop_en = 1'b1;
    exp_b = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
`else
    loop_en = 1'b0;
    exp_b = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd0};
`endif
    play[1] = 1'b1;
    repeat (40) @(negedge clk);
    chk("end_reqs", rd_cnt[1], loop_en ? 8 : 4);
    for (int i = 0; i < 6; i++) begin
      frame(1, exp_b[i], 16);
      chk("end_done", done[1], (!loop_en && i >= 3) ? 1 : 0);
      chk("end_underrun", under[1], 0);
    end
    play[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("stop_done", done[1], 0);

    chk("sb_drain", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_feeder.md
# audio_sample_feeder

Upstream audio stage for the I2S serializer: fetches 16-bit PCM samples from sample memory, buffers them in a small prefetch FIFO, and presents one new sample per I2S frame on the LRCLK falling edge. It sits between the sample memory port and `I2S_Interface`, and is gated by the same play request. All logic runs on the system clock. LRCLK arrives from the I2S clock generator, is treated as asynchronous, and is synchronized internally.

## Interface
- `ADDR_W`, 20, sample memory word-address width
- `DATA_W`, 16, sample width
- `FIFO_DEPTH`, 8, prefetch FIFO entries; must be a power of 2, ≥2
- `START_ADDR`, 0, first sample address
- `LAST_ADDR`, 20'h0FFFF, final sample address (inclusive); must be ≥ `START_ADDR`

Ports:
- `CLK` in 1: system clock; all state on rising edge
- `RESET_N` in 1: reset, asynchronous, active-low
- `PLAY` in 1: level; 1 = playback enabled, 0 = stop and rewind
- `LRCLK` in 1: I2S word-select; asynchronous, double-flop synchronized
- `MEM_ADDR` out `ADDR_W`: read address; valid while `MEM_RD`=1
- `MEM_RD` out 1: one-cycle read request
- `MEM_ACK` in 1: one-cycle pulse; `MEM_DATA` is valid in that cycle
- `MEM_DATA` in `DATA_W`: read data
- `SAMPLE` out `DATA_W`: sample to the serializer; held between updates
- `SAMPLE_STB` out 1: one-cycle pulse on each `SAMPLE` update
- `DONE` out 1: end of non-looping playback
- `UNDERRUN` out 8: saturating count of frames that found the FIFO empty

## Operation
- **Reset values:** `SAMPLE`=0, `SAMPLE_STB`=0, `MEM_RD`=0, `MEM_ADDR`=`START_ADDR`, `DONE`=0, `UNDERRUN`=0. FIFO is empty, fetch FSM is IDLE, and the synchronizer/previous-LRCLK registers are 1.
- **Fetch FSM (IDLE, REQ, WAIT):** at most one request is outstanding.
  - IDLE→REQ when `PLAY` && FIFO count < `FIFO_DEPTH` && !end-reached.
  - REQ: `MEM_RD`=1 for exactly one cycle, then →WAIT.
  - WAIT: remains in WAIT until `MEM_ACK`. On `MEM_ACK`, push `MEM_DATA`, then →IDLE.
  - Address update on push: if address = `LAST_ADDR`, apply the wrap/end rule (see Configuration); otherwise address+1.
- **Pop:** a falling edge of synchronized LRCLK with `PLAY`=1 produces one frame:
  - FIFO non-empty: pop the head into `SAMPLE`.
  - FIFO empty and end not reached: `SAMPLE`←0 and `UNDERRUN`+1, saturating at 255.
  - FIFO empty and end reached: `SAMPLE`←0 with no count.
  - `SAMPLE_STB` pulses in all three cases.
- **Simultaneous push and pop:** FIFO count is unchanged. A pop on an empty FIFO never returns same-cycle push data.
- **`PLAY` falling (level 0):** in each cycle,
  - FIFO is flushed.
  - `SAMPLE`←0, with no strobe.
  - Address ← `START_ADDR`; `DONE`←0.
  - `UNDERRUN` is held.
  - The FSM finishes any WAIT by absorbing and discarding the pending `MEM_ACK`, then stays in IDLE.
- **`UNDERRUN`:** cleared only by reset.

## Timing
- **LRCLK latency:** with LRCLK sampled low at CLK edge 1 (after being high), `SAMPLE`/`SAMPLE_STB` update at edge 3.
- **Memory request rate:** `MEM_RD` can assert at most once per 3 cycles, with a minimum of IDLE→REQ→WAIT(ACK)→IDLE.
- **Memory latency:** any number of cycles is allowed; `MEM_ACK` must not arrive without a request.
- **Prefetch:** the FIFO fills from empty in ≥3·`FIFO_DEPTH` cycles after `PLAY` rises.
- **`DONE`:** asserts the cycle after the FIFO becomes empty with end reached. It stays high until `PLAY`=0 or reset.

## Configuration
- **`AUDIO_FEEDER_LOOP_EN` defined:** after pushing `LAST_ADDR`, the address wraps to `START_ADDR` and fetching continues. End is never reached, and `DONE` stays 0.
- **`AUDIO_FEEDER_LOOP_EN` undefined:** after pushing `LAST_ADDR`, end-reached is set and fetching stops. Remaining samples drain, then `DONE`=1 and frames output 0 without counting underruns.

## Test plan
- **Reset mid-WAIT:** assert `RESET_N`=0 with `MEM_RD` outstanding → all outputs at reset values immediately, asynchronously. After release, no spurious push occurs on a late `MEM_ACK`.
- **Prefetch and steady state:** memory returns data=addr with 2-cycle ACK latency, `PLAY`=1, LRCLK period 64 CLK. Required:
  - FIFO reaches 8 entries.
  - The first pop gives `SAMPLE`=0x0000, then 0x0001, 0x0002, …
  - Each update lands exactly 3 edges after LRCLK falls, with one `SAMPLE_STB` pulse each.
- **Underrun:** memory ACK latency 100 cycles, LRCLK period 16 → `SAMPLE`=0 frames occur and `UNDERRUN` increments once per empty frame. Force 300 empty frames → `UNDERRUN`=255.
- **End of stream, `LAST_ADDR`=3:**
  - Without `AUDIO_FEEDER_LOOP_EN`: samples 0,1,2,3, then 0 with `DONE`=1 and `UNDERRUN` unchanged.
  - With `AUDIO_FEEDER_LOOP_EN`: 0,1,2,3,0,1… and `DONE`=0.
- **Stop/rewind:** `PLAY`→0 while in WAIT, then →1 → the discarded ACK does not push. The next `MEM_ADDR` is `START_ADDR`, and the first popped sample is 0x0000.
- **Simultaneous events:** arrange `MEM_ACK` in the same cycle as a pop with count=1 → count remains 1, and the popped value is the older sample.
